// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART_TX transmit
// channel among NUM_REQ byte requesters and paces writes into the UART_TX
// FIFO so that its registered occupancy always reflects the previous write.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   tx_rstn,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4:0]             tx_fifo_cnt,
    input  logic                   tx_fifo_full,
    output logic [7:0]             tx_in_data,
    output logic                   tx_fifo_write,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   lock_timeout
);

    // Idle-cycle counter only has to reach TIMEOUT-1 before the lock drops.
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2:0]      r_grant;
    logic [2:0]      r_last_grant;
    logic [TW-1:0]   r_to_cnt;
    logic [1:0]      r_space_cnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_write;
    logic            r_busy;
    logic            r_lock_timeout;

    logic            w_valid_g;
    logic            w_last_g;
    logic [7:0]      w_data_sel;
    logic            w_space_ok;
    logic            w_accept;
    logic            w_timeout_hit;
    logic [2:0]      w_pick;
    logic            w_pick_ok;
    logic [3:0]      w_sum;

    // Route the granted requester's valid/last/data onto shared wires.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_valid_g  = 1'b0;
        w_last_g   = 1'b0;
        w_data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_valid_g  = req_valid[i];
                w_last_g   = req_last[i];
                w_data_sel = req_data[8*i +: 8];
            end
        end
    end

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        w_pick    = '0;
        w_pick_ok = 1'b0;
        w_sum     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_grant} + 4'(k);
            if (w_sum >= 4'(NUM_REQ)) begin
                w_sum = w_sum - 4'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_pick_ok && req_valid[i] && (w_sum == 4'(i))) begin
                    w_pick_ok = 1'b1;
                    w_pick    = 3'(i);
                end
            end
        end
    end

    // Two idle cycles after each accept let the registered FIFO count catch up.
    assign w_space_ok = (r_space_cnt == 2'd0);
    assign w_accept   = (r_state == S_LOCK) && w_valid_g && !tx_fifo_full &&
                        (tx_fifo_cnt < 5'(FIFO_DEPTH)) && w_space_ok;

    // Only the granted requester ever sees ready, and only on an accept.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && (r_grant == 3'(i));
        end
    end

    // Next-state logic: packet end or lock timeout returns to IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_ok) begin
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_accept && w_last_g) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_valid_g && (r_to_cnt == TW'(TIMEOUT - 1))) begin
                    // A valid in the same cycle wins, so this only fires when idle.
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant register and rotation pointer; rotation resumes after the last owner.
    always_ff @(posedge clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_grant      <= '0;
            r_last_grant <= 3'(NUM_REQ - 1);
        end else begin
            if (r_state == S_IDLE && w_pick_ok) begin
                r_grant <= w_pick;
            end
            if ((w_accept && w_last_g) || w_timeout_hit) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Lock timeout counter: counts idle LOCK cycles, clears on any valid.
    always_ff @(posedge clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_to_cnt <= '0;
        end else if (r_state == S_LOCK && !w_valid_g && !w_timeout_hit) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Accept spacing counter.
    always_ff @(posedge clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_space_cnt <= '0;
        end else if (w_accept) begin
            r_space_cnt <= 2'd2;
        end else if (r_space_cnt != 2'd0) begin
            r_space_cnt <= r_space_cnt - 2'd1;
        end
    end

    // Registered outputs toward UART_TX and status; data holds between writes.
    always_ff @(posedge clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_tx_data      <= '0;
            r_tx_write     <= 1'b0;
            r_busy         <= 1'b0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_tx_write     <= w_accept;
            r_busy         <= (w_state_nxt == S_LOCK);
            r_lock_timeout <= w_timeout_hit;
            if (w_accept) begin
                r_tx_data <= w_data_sel;
            end
        end
    end

    assign tx_in_data    = r_tx_data;
    assign tx_fifo_write = r_tx_write;
    assign grant_id      = r_grant;
    assign busy          = r_busy;
    assign lock_timeout  = r_lock_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART_TX transmit channel among `NUM_REQ` byte requesters and sequences writes into the UART_TX FIFO. Arbitration is round-robin at packet granularity: a granted requester holds the channel until its `last` byte is accepted, or until a lock timeout expires. The block sits between the requester logic and the UART_TX `tx_in_data` / `tx_fifo_write` / `tx_fifo_cnt` / `tx_fifo_full` ports, on the UART_TX clock and reset.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `FIFO_DEPTH`, 16: UART_TX FIFO depth; `tx_fifo_cnt` saturates here.
- `TIMEOUT`, 1024: idle cycles a locked requester may leave `req_valid` low before its lock is dropped; ≥2.
- `clk` in 1: 50 MHz system clock; the only clock.
- `tx_rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8·NUM_REQ: byte of requester i on `[8i+7:8i]`.
- `req_last` in NUM_REQ: byte is the last of its packet.
- `req_ready` out NUM_REQ: combinational; byte of requester i accepted this cycle.
- `tx_fifo_cnt` in 5: UART_TX FIFO occupancy, registered in UART_TX.
- `tx_fifo_full` in 1: UART_TX FIFO full.
- `tx_in_data` out 8: byte to UART_TX; registered.
- `tx_fifo_write` out 1: one-cycle FIFO write pulse; registered.
- `grant_id` out 3: index of the current or last grant; registered.
- `busy` out 1: high while in LOCK; registered.
- `lock_timeout` out 1: one-cycle pulse when a lock is dropped by timeout.

## Operation
- States: IDLE, LOCK.
- **IDLE**
  - If no `req_valid` is set, stay in IDLE.
  - Otherwise pick the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Load `grant_id`, set `busy`, enter LOCK next cycle. No byte is accepted in the arbitration cycle.
- **LOCK, accept condition** (g = `grant_id`): `req_valid[g]` AND `!tx_fifo_full` AND `tx_fifo_cnt < FIFO_DEPTH` AND `space_ok`.
- **On accept**
  - `req_ready[g]` = 1 combinationally; every other `req_ready` bit is always 0.
  - Next cycle: `tx_in_data` = byte and `tx_fifo_write` = 1 for exactly one cycle.
- **space_ok**
  - Low in the cycle after an accept and in the cycle after that.
  - Accepts are therefore at least 3 cycles apart, so the registered FIFO status always includes the previous write.
- **Accept with `req_last[g]`**: `last_grant` ← g; return to IDLE next cycle; `busy` clears.
- **Timeout counter**
  - Counts while in LOCK with `req_valid[g]` low.
  - Clears on any cycle where `req_valid[g]` is high, whether or not the FIFO can take the byte. A full FIFO never causes a timeout.
  - On reaching TIMEOUT: pulse `lock_timeout`, `last_grant` ← g, go to IDLE, counter clears.
- Requests from other requesters are ignored while in LOCK.
- `req_valid` that drops without an accept is legal. No data is captured.
- `tx_in_data` holds its last value between writes.

## Timing
- **Reset values:** `req_ready`=0, `tx_fifo_write`=0, `tx_in_data`=0, `grant_id`=0, `busy`=0, `lock_timeout`=0, `last_grant`=NUM_REQ-1 (requester 0 wins first), timeout counter=0, state IDLE.
- **Reset asserted mid-operation:** all of the above apply immediately and asynchronously. A pending write pulse is lost. The partial packet is not completed.
- **Latency, idle system:** request at cycle t → grant registered at t+1 → first accept at t+1 → FIFO write at t+2.
- **Throughput:** one byte per 3 cycles maximum, far above any UART bit rate.
- **Simultaneous events:**
  - Accept of a `last` byte together with other requests: re-arbitration happens in the next IDLE cycle and the rotation starts after g.
  - Timeout and `req_valid[g]` rising in the same cycle: valid wins; counter clears and no timeout fires.
- **FIFO near full:** at `tx_fifo_cnt` = FIFO_DEPTH-1 one more byte is accepted, then acceptance stalls until the count drops.

## Test plan
- **Single packet.** Reset, then requester 2 sends bytes 0x08..0x0B with `last` on 0x0B.
  - `grant_id`=2.
  - Four `tx_fifo_write` pulses carry 0x08..0x0B in order, each ≥3 cycles apart.
  - `busy` clears one cycle after the 0x0B accept.
- **Round-robin.** All four requesters hold 2-byte packets continuously from reset.
  - Grant order is 0,1,2,3,0.
  - No bytes from different requesters interleave within a packet.
- **Backpressure.** Force `tx_fifo_cnt`=16 and `tx_fifo_full`=1 with requester 1 valid for 5000 cycles.
  - No `req_ready` and no `lock_timeout`.
  - After release, the byte is written within 1 cycle of acceptance.
- **Timeout.** Requester 3 is granted, sends one non-last byte, then drops valid.
  - `lock_timeout` pulses exactly TIMEOUT cycles later.
  - The next request from requester 0 is granted.
- **Reset mid-packet.** Assert `tx_rstn`=0 in the cycle `tx_fifo_write`=1.
  - All outputs are 0 immediately.
  - After release, requester 0 has priority again.
- **Back-to-back spacing.** Requester 0 streams 16 bytes with UART_TX draining.
  - Bytes are written in order with no drops or duplicates.
  - Accepts are exactly 3 cycles apart while the FIFO has space.
